frog_controller: RTL and testbench

FROG_CONTROLLER -- requirements
Module: frog_controller

---
 rtl/frogger_pkg.sv | 44 ++++
 rtl/frog_controller_key_edge_detect.sv | 34 +++
 rtl/frog_controller.sv | 176 +++++++++++++++++
 tb/tb_frog_controller.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared types and constants for the frog controller slice.
// FROG_TIMEOUT_EN (in frog_controller) adds an optional per-attempt frame limit.
package frogger_pkg;

    typedef enum logic [2:0] {
        ST_SPAWN  = 3'd0,
        ST_PLAY   = 3'd1,
        ST_DYING  = 3'd2,
        ST_HOMED  = 3'd3,
        ST_FROZEN = 3'd4
    } frog_state_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [10:0] HOME_X0 = 11'd120;
    localparam logic [10:0] HOME_X1 = 11'd280;
    localparam logic [10:0] HOME_X2 = 11'd480;

    localparam logic [10:0] OFF_X = 11'd640;
    localparam logic [10:0] OFF_Y = 11'd480;

    localparam logic [10:0] X_MIN = 11'd0;
    localparam logic [10:0] X_MAX = 11'd600;
    localparam logic [10:0] Y_MIN = 11'd40;
    localparam logic [10:0] Y_MAX = 11'd440;

    // One-hot home slot for an X coordinate, zero when X is not a slot.
    function automatic logic [2:0] home_slot(input logic [10:0] x);
        home_slot = 3'b000;
        if (x == HOME_X0) home_slot = 3'b001;
        if (x == HOME_X1) home_slot = 3'b010;
        if (x == HOME_X2) home_slot = 3'b100;
    endfunction

endpackage

// File: rtl/frog_controller_key_edge_detect.sv
// Turns a held USB keycode into a single-frame move strobe plus direction.
module key_edge_detect
    import frogger_pkg::*;
(
    input  logic       frame_clk,
    input  logic       game_restart,
    input  logic [7:0] keycode,
    output logic       move,
    output logic [1:0] dir
);

    logic [7:0] prev_key;
    logic       known;

    always_ff @(posedge frame_clk) begin
        if (game_restart) prev_key <= KEY_NONE;
        else              prev_key <= keycode;
    end

    // A press counts only when the previous frame had no key at all.
    always_comb begin
        dir   = DIR_UP;
        known = 1'b1;
        case (keycode)
            KEY_UP:    dir = DIR_UP;
            KEY_DOWN:  dir = DIR_DOWN;
            KEY_LEFT:  dir = DIR_LEFT;
            KEY_RIGHT: dir = DIR_RIGHT;
            default:   known = 1'b0;
        endcase
        move = known && (prev_key == KEY_NONE);
    end

endmodule

// File: rtl/frog_controller.sv
// Frog movement, death/respawn and homing controller, stepped once per video frame.
// Define FROG_TIMEOUT_EN to kill the active frog after TIME_LIMIT PLAY frames.
module frog_controller
    import frogger_pkg::*;
#(
    parameter int STEP           = 40,
    parameter int START_X        = 280,
    parameter int START_Y        = 440,
    parameter int RESPAWN_FRAMES = 30,
    parameter int TIME_LIMIT     = 600
) (
    input  logic        frame_clk,
    input  logic        game_restart,
    input  logic [7:0]  keycode,
    input  logic        hazard_hit,
    input  logic        win_game,
    input  logic        lose_game,
    output logic [10:0] Frog1_X,
    output logic [10:0] Frog1_Y,
    output logic [10:0] Frog2_X,
    output logic [10:0] Frog2_Y,
    output logic [10:0] Frog3_X,
    output logic [10:0] Frog3_Y,
    output logic        dead_frog,
    output logic [1:0]  active_frog,
    output logic [2:0]  home_mask,
    output logic [2:0]  state_dbg
);

    localparam logic [10:0] SX        = 11'(START_X);
    localparam logic [10:0] SY        = 11'(START_Y);
    localparam logic [11:0] STEP_W    = 12'(STEP);
    localparam logic [15:0] RESP_LAST = 16'(RESPAWN_FRAMES - 1);

    frog_state_t state, state_n;
    logic [10:0] fx [3];
    logic [10:0] fy [3];
    logic [10:0] fx_n [3];
    logic [10:0] fy_n [3];
    logic [1:0]  active_n, next_idx;
    logic [2:0]  mask_n, slot;
    logic        dead_n, move, in_range, timeout;
    logic [1:0]  dir;
    logic [15:0] resp_cnt, resp_n;
    logic [11:0] cx, cy, tx, ty;

    key_edge_detect u_key (
        .frame_clk    (frame_clk),
        .game_restart (game_restart),
        .keycode      (keycode),
        .move         (move),
        .dir          (dir)
    );

`ifdef FROG_TIMEOUT_EN
    localparam logic [15:0] TIME_LAST = 16'(TIME_LIMIT - 1);
    logic [15:0] attempt_timer;

    // Cleared outside PLAY, so SPAWN starts every attempt from zero.
    always_ff @(posedge frame_clk) begin
        if (game_restart || state != ST_PLAY) attempt_timer <= '0;
        else                                  attempt_timer <= attempt_timer + 16'd1;
    end
    assign timeout = (state == ST_PLAY) && (attempt_timer == TIME_LAST);
`else
    localparam int unused_time_limit = TIME_LIMIT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        cx       = {1'b0, fx[active_frog]};
        cy       = {1'b0, fy[active_frog]};
        tx       = cx;
        ty       = cy;
        in_range = 1'b0;
        case (dir)
            DIR_UP:    begin ty = cy - STEP_W; in_range = cy >= {1'b0, Y_MIN} + STEP_W; end
            DIR_DOWN:  begin ty = cy + STEP_W; in_range = cy + STEP_W <= {1'b0, Y_MAX}; end
            DIR_LEFT:  begin tx = cx - STEP_W; in_range = cx >= {1'b0, X_MIN} + STEP_W; end
            default:   begin tx = cx + STEP_W; in_range = cx + STEP_W <= {1'b0, X_MAX}; end
        endcase
        slot = home_slot(tx[10:0]);
    end

    always_comb begin
        state_n  = state;
        fx_n     = fx;
        fy_n     = fy;
        active_n = active_frog;
        mask_n   = home_mask;
        dead_n   = 1'b0;
        resp_n   = resp_cnt;
        next_idx = active_frog + 2'd1;
        if (win_game || lose_game) begin
            state_n = ST_FROZEN;
        end else begin
            case (state)
                ST_SPAWN: state_n = ST_PLAY;
                ST_PLAY: begin
                    // Death outranks both movement and homing in the same frame.
                    if (hazard_hit || timeout) begin
                        state_n = ST_DYING;
                        dead_n  = 1'b1;
                        resp_n  = '0;
                    end else if (move && in_range) begin
                        fx_n[active_frog] = tx[10:0];
                        fy_n[active_frog] = ty[10:0];
                        if (ty[10:0] == Y_MIN) begin
                            if ((slot & ~home_mask) != 3'b000) begin
                                mask_n  = home_mask | slot;
                                state_n = ST_HOMED;
                            end else begin
                                state_n = ST_DYING;
                                dead_n  = 1'b1;
                                resp_n  = '0;
                            end
                        end
                    end
                end
                ST_DYING: begin
                    if (resp_cnt == RESP_LAST) begin
                        state_n           = ST_SPAWN;
                        fx_n[active_frog] = SX;
                        fy_n[active_frog] = SY;
                    end else begin
                        resp_n = resp_cnt + 16'd1;
                    end
                end
                ST_HOMED: begin
                    if (active_frog == 2'd2) begin
                        state_n = ST_FROZEN;
                    end else begin
                        active_n       = next_idx;
                        fx_n[next_idx] = SX;
                        fy_n[next_idx] = SY;
                        state_n        = ST_SPAWN;
                    end
                end
                default: state_n = ST_FROZEN;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (game_restart) begin
            state       <= ST_SPAWN;
            active_frog <= 2'd0;
            home_mask   <= 3'b000;
            dead_frog   <= 1'b0;
            resp_cnt    <= '0;
            fx[0]       <= SX;
            fy[0]       <= SY;
            fx[1]       <= OFF_X;
            fy[1]       <= OFF_Y;
            fx[2]       <= OFF_X;
            fy[2]       <= OFF_Y;
        end else begin
            state       <= state_n;
            active_frog <= active_n;
            home_mask   <= mask_n;
            dead_frog   <= dead_n;
            resp_cnt    <= resp_n;
            fx          <= fx_n;
            fy          <= fy_n;
        end
    end

    assign Frog1_X   = fx[0];
    assign Frog1_Y   = fy[0];
    assign Frog2_X   = fx[1];
    assign Frog2_Y   = fy[1];
    assign Frog3_X   = fx[2];
    assign Frog3_Y   = fy[2];
    assign state_dbg = state;

endmodule

// File: tb/tb_frog_controller.sv
// Self-checking bench for frog_controller: movement, bounds, death, homing, freeze, restart.
module tb_frog_controller;

    logic        frame_clk = 1'b0;
    logic        game_restart = 1'b1;
    logic [7:0]  keycode = 8'h00;
    logic        hazard_hit = 1'b0;
    logic        win_game = 1'b0;
    logic        lose_game = 1'b0;
    logic [10:0] Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y;
    logic        dead_frog;
    logic [1:0]  active_frog;
    logic [2:0]  home_mask;
    logic [2:0]  state_dbg;

    int tests = 0;
    int fails = 0;

    logic [21:0] exp_q[$];
    logic [10:0] ex, ey;
    logic [1:0]  exp_act;
    logic        last_dead;

    always #5 frame_clk = ~frame_clk;

    frog_controller dut (
        .frame_clk    (frame_clk),
        .game_restart (game_restart),
        .keycode      (keycode),
        .hazard_hit   (hazard_hit),
        .win_game     (win_game),
        .lose_game    (lose_game),
        .Frog1_X      (Frog1_X),
        .Frog1_Y      (Frog1_Y),
        .Frog2_X      (Frog2_X),
        .Frog2_Y      (Frog2_Y),
        .Frog3_X      (Frog3_X),
        .Frog3_Y      (Frog3_Y),
        .dead_frog    (dead_frog),
        .active_frog  (active_frog),
        .home_mask    (home_mask),
        .state_dbg    (state_dbg)
    );

`ifdef FROG_TIMEOUT_EN
    logic [10:0] t1x, t1y, t2x, t2y, t3x, t3y;
    logic        t_dead;
    logic [1:0]  t_act;
    logic [2:0]  t_mask, t_state;

    frog_controller #(.TIME_LIMIT(5)) dut_to (
        .frame_clk    (frame_clk),
        .game_restart (game_restart),
        .keycode      (keycode),
        .hazard_hit   (hazard_hit),
        .win_game     (win_game),
        .lose_game    (lose_game),
        .Frog1_X      (t1x),
        .Frog1_Y      (t1y),
        .Frog2_X      (t2x),
        .Frog2_Y      (t2y),
        .Frog3_X      (t3x),
        .Frog3_Y      (t3y),
        .dead_frog    (t_dead),
        .active_frog  (t_act),
        .home_mask    (t_mask),
        .state_dbg    (t_state)
    );
`endif

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    function automatic logic [21:0] cur_pos();
        case (exp_act)
            2'd0:    return {Frog1_X, Frog1_Y};
            2'd1:    return {Frog2_X, Frog2_Y};
            default: return {Frog3_X, Frog3_Y};
        endcase
    endfunction

    // One press frame then one release frame; expected position queued at drive time.
    task automatic press(input logic [7:0] k);
        logic [10:0] nx, ny;
        logic [21:0] got, exp;
        nx = ex;
        ny = ey;
        case (k)
            8'h1A: if (ey >= 11'd80)  ny = ey - 11'd40;
            8'h16: if (ey <= 11'd400) ny = ey + 11'd40;
            8'h04: if (ex >= 11'd40)  nx = ex - 11'd40;
            8'h07: if (ex <= 11'd560) nx = ex + 11'd40;
            default: ;
        endcase
        exp_q.push_back({nx, ny});
        keycode = k;
        tick();
        last_dead = dead_frog;
        got = cur_pos();
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL press_pos key=%h: got (%0d,%0d) expected (%0d,%0d)",
                     k, got[21:11], got[10:0], exp[21:11], exp[10:0]);
        end
        ex = nx;
        ey = ny;
        keycode = 8'h00;
        tick();
    endtask

    task automatic do_restart();
        game_restart = 1'b1;
        tick();
        game_restart = 1'b0;
        exp_act = 2'd0;
        ex = 11'd280;
        ey = 11'd440;
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if ({Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y} !==
            {11'd280, 11'd440, 11'd640, 11'd480, 11'd640, 11'd480}) begin
            fails++;
            $display("FAIL %s pos: got F1(%0d,%0d) F2(%0d,%0d) F3(%0d,%0d)", name,
                     Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y);
        end
        tests++;
        if ({dead_frog, active_frog, home_mask, state_dbg} !== {1'b0, 2'd0, 3'b000, 3'd0}) begin
            fails++;
            $display("FAIL %s flags: got dead=%b act=%0d mask=%b st=%0d expected 0/0/000/0",
                     name, dead_frog, active_frog, home_mask, state_dbg);
        end
    endtask

    task automatic test_reset();
        keycode = 8'h1A;
        hazard_hit = 1'b1;
        tick();
        tick();
        keycode = 8'h00;
        hazard_hit = 1'b0;
        do_restart();
        check_reset_values("reset");
        tick();
    endtask

    task automatic test_move_up();
        press(8'h1A);
        tests++;
        if (last_dead !== 1'b0) begin
            fails++;
            $display("FAIL move_up_dead: got %b expected 0", last_dead);
        end
    endtask

    task automatic test_bounds();
        logic [21:0] got, exp;
        exp_q.push_back({11'd320, ey});
        keycode = 8'h07;
        for (int i = 0; i < 10; i++) tick();
        got = {Frog1_X, Frog1_Y};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL held_key: got (%0d,%0d) expected (%0d,%0d)",
                     got[21:11], got[10:0], exp[21:11], exp[10:0]);
        end
        ex = 11'd320;
        keycode = 8'h00;
        tick();
        for (int i = 0; i < 8; i++) press(8'h07);
        for (int i = 0; i < 3; i++) press(8'($urandom_range(8, 21)));
        for (int i = 0; i < 8; i++) press(8'h04);
        press(8'h16);
        press(8'h16);
        for (int i = 0; i < 6; i++) press(8'h1A);
    endtask

    task automatic test_hazard();
        int extra;
        keycode = 8'h1A;
        hazard_hit = 1'b1;
        tick();
        tests++;
        if ({dead_frog, Frog1_Y} !== {1'b1, 11'd200}) begin
            fails++;
            $display("FAIL hazard_death: got dead=%b y=%0d expected dead=1 y=200", dead_frog, Frog1_Y);
        end
        keycode = 8'h00;
        extra = 0;
        for (int i = 1; i < 30; i++) begin
            tick();
            if (dead_frog) extra++;
        end
        tests++;
        if ({extra[7:0], Frog1_Y} !== {8'd0, 11'd200}) begin
            fails++;
            $display("FAIL dying_hold: got extra_pulses=%0d y=%0d expected 0 and 200", extra, Frog1_Y);
        end
        tick();
        tests++;
        if ({Frog1_X, Frog1_Y, active_frog} !== {11'd280, 11'd440, 2'd0}) begin
            fails++;
            $display("FAIL respawn: got (%0d,%0d) act=%0d expected (280,440) act=0",
                     Frog1_X, Frog1_Y, active_frog);
        end
        tick();
        hazard_hit = 1'b0;
        tests++;
        if (dead_frog !== 1'b0) begin
            fails++;
            $display("FAIL spawn_hazard_ignored: got dead=%b expected 0", dead_frog);
        end
        ex = 11'd280;
        ey = 11'd440;
    endtask

    task automatic test_home();
        for (int i = 0; i < 10; i++) press(8'h1A);
        exp_act = 2'd1;
        ex = 11'd280;
        ey = 11'd440;
        tests++;
        if ({home_mask, active_frog, Frog2_X, Frog2_Y} !== {3'b010, 2'd1, 11'd280, 11'd440}) begin
            fails++;
            $display("FAIL home_first: got mask=%b act=%0d F2(%0d,%0d) expected 010 1 (280,440)",
                     home_mask, active_frog, Frog2_X, Frog2_Y);
        end
        tick();
        for (int i = 0; i < 10; i++) press(8'h1A);
        tests++;
        if ({last_dead, home_mask} !== {1'b1, 3'b010}) begin
            fails++;
            $display("FAIL occupied_slot: got dead=%b mask=%b expected 1 010", last_dead, home_mask);
        end
        for (int i = 0; i < 29; i++) tick();
        tests++;
        if ({Frog2_X, Frog2_Y, active_frog} !== {11'd280, 11'd440, 2'd1}) begin
            fails++;
            $display("FAIL respawn_frog2: got (%0d,%0d) act=%0d expected (280,440) 1",
                     Frog2_X, Frog2_Y, active_frog);
        end
        tick();
        ex = 11'd280;
        ey = 11'd440;
    endtask

    task automatic test_home_all();
        logic [65:0] snap;
        logic [7:0]  keys [5];
        keys = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07};
        for (int i = 0; i < 4; i++) press(8'h04);
        for (int i = 0; i < 10; i++) press(8'h1A);
        exp_act = 2'd2;
        ex = 11'd280;
        ey = 11'd440;
        tick();
        for (int i = 0; i < 5; i++) press(8'h07);
        for (int i = 0; i < 10; i++) press(8'h1A);
        tests++;
        if ({home_mask, active_frog, state_dbg} !== {3'b111, 2'd2, 3'd4}) begin
            fails++;
            $display("FAIL home_all: got mask=%b act=%0d st=%0d expected 111 2 4",
                     home_mask, active_frog, state_dbg);
        end
        snap = {11'd280, 11'd40, 11'd120, 11'd40, 11'd480, 11'd40};
        for (int i = 0; i < 12; i++) begin
            keycode = keys[$urandom_range(0, 4)];
            hazard_hit = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if ({Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y} !== snap ||
                {dead_frog, home_mask, state_dbg} !== {1'b0, 3'b111, 3'd4}) begin
                fails++;
                $display("FAIL frozen_hold: got F1(%0d,%0d) F2(%0d,%0d) F3(%0d,%0d) dead=%b st=%0d",
                         Frog1_X, Frog1_Y, Frog2_X, Frog2_Y, Frog3_X, Frog3_Y, dead_frog, state_dbg);
            end
        end
        keycode = 8'h00;
        hazard_hit = 1'b0;
        tick();
    endtask

    task automatic test_restart_dying();
        do_restart();
        tick();
        press(8'h1A);
        hazard_hit = 1'b1;
        tick();
        hazard_hit = 1'b0;
        tests++;
        if (dead_frog !== 1'b1) begin
            fails++;
            $display("FAIL second_death: got dead=%b expected 1", dead_frog);
        end
        for (int i = 0; i < 5; i++) tick();
        do_restart();
        check_reset_values("restart_dying");
        tick();
        tests++;
        if ({dead_frog, state_dbg} !== {1'b0, 3'd1}) begin
            fails++;
            $display("FAIL after_restart: got dead=%b st=%0d expected 0 1", dead_frog, state_dbg);
        end
    endtask

    task automatic test_win_freeze();
        press(8'h1A);
        win_game = 1'b1;
        tick();
        win_game = 1'b0;
        keycode = 8'h1A;
        tick();
        keycode = 8'h00;
        tick();
        tests++;
        if ({state_dbg, Frog1_Y} !== {3'd4, 11'd400}) begin
            fails++;
            $display("FAIL win_freeze: got st=%0d y=%0d expected 4 400", state_dbg, Frog1_Y);
        end
    endtask

`ifdef FROG_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        do_restart();
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (t_dead) pulses++;
            if (i == 6) begin
                tests++;
                if (t_dead !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_edge: got dead=%b expected 1 after 5 PLAY frames", t_dead);
                end
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL timeout_pulses: got %0d expected 1", pulses);
        end
    endtask
`endif

    initial begin
        exp_act = 2'd0;
        ex = 11'd280;
        ey = 11'd440;
        last_dead = 1'b0;
        test_reset();
        test_move_up();
        test_bounds();
        test_hazard();
        test_home();
        test_home_all();
        test_restart_dying();
        test_win_freeze();
`ifdef FROG_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
